// File: rtl/nios2os_desc_pkg.sv
// Shared types and constants for the nios2os descriptor walker:
// FSM state encoding, descriptor word offsets, control-word bit positions
// and the packing of the status word written back on completion.
package nios2os_desc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_CMP = 3'd4,
        ST_WB       = 3'd5
    } state_e;

    // Word offsets inside a 4-word descriptor.
    localparam logic [1:0] OFS_BUF  = 2'd0;
    localparam logic [1:0] OFS_NEXT = 2'd1;
    localparam logic [1:0] OFS_LEN  = 2'd2;
    localparam logic [1:0] OFS_CTRL = 2'd3;

    // Control/status word bit positions.
    localparam int OWN_BIT = 31;
    localparam int EOP_BIT = 30;
    localparam int ERR_BIT = 29;

    // Status word handed back to software: OWN cleared, EOP preserved,
    // DMA error flag, and the length the engine actually moved.
    function automatic logic [31:0] pack_status(input logic        eop,
                                                input logic        err,
                                                input logic [15:0] len);
        logic [31:0] w;
        w          = '0;
        w[EOP_BIT] = eop;
        w[ERR_BIT] = err;
        w[15:0]    = len;
        return w;
    endfunction

endpackage

// File: rtl/nios2os_desc_fetch.sv
// Scatter-gather descriptor walker on port 2 of the descriptor memory.
// Fetches 4-word descriptors, checks ownership, issues buffer commands to
// the DMA engine, and follows the next pointer until the chain ends.
// Build option: NIOS2OS_DESC_FETCH_WRITEBACK_EN adds the status writeback
// state; without it completions go straight to the next fetch.
module nios2os_desc_fetch
    import nios2os_desc_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int LEN_W     = 16,
    parameter int MAX_CHAIN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] head_ptr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        desc_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_buf_addr,
    output logic [LEN_W-1:0]  desc_len,
    output logic              desc_eop,
    input  logic              cmp_valid,
    input  logic [LEN_W-1:0]  cmp_len,
    input  logic              cmp_error
);

    state_e            state;
    logic [31:0]       desc_words [4];
    logic              rd_pend;
    logic [1:0]        rd_idx;
    logic [ADDR_W-1:0] base_ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic              adv;
    logic              adv_err;
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
    logic              cmp_err_q;
`endif

    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign busy           = (state != ST_IDLE);
    assign next_ptr       = desc_words[OFS_NEXT][ADDR_W-1:0];
    assign desc_buf_addr  = desc_words[OFS_BUF];
    assign desc_len       = desc_words[OFS_LEN][LEN_W-1:0];
    assign desc_eop       = desc_words[OFS_CTRL][EOP_BIT];

    // Bits of the captured words and completion length that no logic consumes.
    logic unused_bits;
    assign unused_bits = ^{desc_words[OFS_NEXT], desc_words[OFS_LEN],
                           desc_words[OFS_CTRL], cmp_len};

    // Decide when the current descriptor is finished and the walker moves on.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        adv     = 1'b0;
        adv_err = 1'b0;
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
        adv     = (state == ST_WB);
        adv_err = cmp_err_q;
`else
        adv     = (state == ST_WAIT_CMP) && cmp_valid;
        adv_err = cmp_error;
`endif
    end

    // Capture read data one cycle after each read address, indexed by the
    // word offset that was presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
            rd_idx  <= '0;
            // NOTE: this 4-word file drives the command outputs directly, so it
            // is reset like any other register; a large RAM would not be.
            for (int i = 0; i < 4; i++) desc_words[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            rd_pend <= mem_chipselect & ~mem_write;
            rd_idx  <= mem_address[1:0];
            if (rd_pend) desc_words[rd_idx] <= mem_readdata;
        end
    end

    // Walker FSM: fetch, check, issue, wait for completion, write back, chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            base_ptr       <= '0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            desc_valid     <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            desc_count     <= '0;
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
            cmp_err_q      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE && state != ST_WB) begin
                state          <= ST_IDLE;
                desc_valid     <= 1'b0;
                mem_chipselect <= 1'b0;
                done           <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            desc_count <= '0;
                            if (head_ptr[1:0] != 2'b00) begin
                                error <= 1'b1;
                                done  <= 1'b1;
                            end else begin
                                error          <= 1'b0;
                                base_ptr       <= head_ptr;
                                mem_address    <= head_ptr;
                                mem_chipselect <= 1'b1;
                                state          <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (mem_address[1:0] == OFS_CTRL) begin
                            mem_chipselect <= 1'b0;
                            state          <= ST_CHECK;
                        end else begin
                            mem_address <= mem_address + ADDR_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        // The control word is on the read bus this cycle.
                        if (!mem_readdata[OWN_BIT]) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else if (next_ptr[1:0] != 2'b00 ||
                                     desc_count == 8'(MAX_CHAIN)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            desc_valid <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (desc_ready) begin
                            desc_valid <= 1'b0;
                            state      <= ST_WAIT_CMP;
                        end
                    end
                    ST_WAIT_CMP: begin
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
                        if (cmp_valid) begin
                            mem_address    <= base_ptr | ADDR_W'(OFS_CTRL);
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_writedata  <= pack_status(desc_words[OFS_CTRL][EOP_BIT],
                                                          cmp_error, 16'(cmp_len));
                            cmp_err_q      <= cmp_error;
                            state          <= ST_WB;
                        end
`endif
                    end
                    ST_WB: begin
                        mem_write <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase

                if (adv) begin
                    desc_count <= desc_count + 8'd1;
                    if (adv_err) begin
                        error          <= 1'b1;
                        done           <= 1'b1;
                        mem_chipselect <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        base_ptr       <= next_ptr;
                        mem_address    <= next_ptr;
                        mem_chipselect <= 1'b1;
                        state          <= ST_FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2os_desc_fetch.sv
// Self-checking bench for nios2os_desc_fetch: memory model on port 2, a DMA
// engine model, and a monitor that pops expected handshakes, writebacks and
// done events from queues filled by the directed tests.
module tb_nios2os_desc_fetch;

    localparam int ADDR_W    = 7;
    localparam int LEN_W     = 16;
    localparam int MAX_CHAIN = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] head_ptr = '0;
    logic              busy, done, error;
    logic [7:0]        desc_count;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata = '0;
    logic              desc_valid;
    logic              desc_ready = 1'b0;
    logic [31:0]       desc_buf_addr;
    logic [LEN_W-1:0]  desc_len;
    logic              desc_eop;
    logic              cmp_valid = 1'b0;
    logic [LEN_W-1:0]  cmp_len = '0;
    logic              cmp_error = 1'b0;

    always #5 clk = ~clk;

    nios2os_desc_fetch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CHAIN(MAX_CHAIN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .head_ptr(head_ptr),
        .busy(busy), .done(done), .error(error), .desc_count(desc_count),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_clken(mem_clken),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_buf_addr(desc_buf_addr),
        .desc_len(desc_len), .desc_eop(desc_eop),
        .cmp_valid(cmp_valid), .cmp_len(cmp_len), .cmp_error(cmp_error)
    );

    typedef struct packed { logic [31:0] addr; logic [15:0] len; logic eop; } hs_t;
    typedef struct packed { logic [6:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic err; logic [7:0] cnt; } done_t;
    typedef struct packed { logic skip; logic err; logic [15:0] len; } rsp_t;

    hs_t   exp_hs[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];
    rsp_t  rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int cs_cnt   = 0;
    int stall_cfg = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Descriptor memory, port 2: registered read, write-through on strobe.
    logic [31:0] mem [128];
    logic        bd_we = 1'b0;
    logic [6:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write) mem_readdata <= mem[mem_address];
    end

    task automatic poke(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic poke_desc(input logic [6:0] b, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        poke(b, w0); poke(b + 7'd1, w1); poke(b + 7'd2, w2); poke(b + 7'd3, w3);
    endtask

    // DMA engine model: ready after stall_cfg cycles, completion 3 cycles later.
    initial begin
        int   stall;
        int   cmp_wait;
        logic cmp_pend;
        rsp_t r;
        stall = 0; cmp_wait = 0; cmp_pend = 1'b0;
        forever begin
            @(negedge clk);
            cmp_valid = 1'b0;
            if (cmp_pend) begin
                if (cmp_wait > 0) cmp_wait--;
                else begin
                    cmp_pend = 1'b0;
                    r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '{skip: 1'b1, err: 1'b0, len: 16'd0};
                    if (!r.skip) begin
                        cmp_valid = 1'b1; cmp_error = r.err; cmp_len = r.len;
                    end
                end
            end
            if (desc_ready) begin
                desc_ready = 1'b0; stall = 0; cmp_pend = 1'b1; cmp_wait = 2;
            end else if (desc_valid) begin
                if (stall >= stall_cfg) desc_ready = 1'b1;
                else stall++;
            end
        end
    end

    // Monitor: compares every handshake, memory write and done pulse.
    initial begin
        hs_t   eh;
        wr_t   ew;
        done_t ed;
        logic        prev_valid, prev_ready, prev_eop;
        logic [31:0] prev_buf;
        logic [15:0] prev_len;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_eop = 1'b0; prev_buf = '0; prev_len = '0;
        forever begin
            @(negedge clk); #2;
            if (reset_n) begin
                if (prev_valid && !prev_ready) begin
                    check("desc_valid held while stalled", {31'd0, desc_valid}, 32'd1);
                    check("desc_buf_addr stable", desc_buf_addr, prev_buf);
                    check("desc_len stable", {16'd0, desc_len}, {16'd0, prev_len});
                    check("desc_eop stable", {31'd0, desc_eop}, {31'd0, prev_eop});
                end
                if (desc_valid && desc_ready) begin
                    hs_cnt++;
                    check("handshake expected", exp_hs.size(), (exp_hs.size() == 0) ? 32'd1 : exp_hs.size());
                    if (exp_hs.size() != 0) begin
                        eh = exp_hs.pop_front();
                        check("desc_buf_addr", desc_buf_addr, eh.addr);
                        check("desc_len", {16'd0, desc_len}, {16'd0, eh.len});
                        check("desc_eop", {31'd0, desc_eop}, {31'd0, eh.eop});
                    end
                end
                if (mem_chipselect) cs_cnt++;
                if (mem_chipselect && mem_write) begin
                    check("write expected (addr shown)", {25'd0, mem_address},
                          (exp_wr.size() == 0) ? 32'hFFFF_FFFF : {25'd0, exp_wr[0].addr});
                    if (exp_wr.size() != 0) begin
                        ew = exp_wr.pop_front();
                        check("writeback data", mem_writedata, ew.data);
                        check("writeback byteenable", {28'd0, mem_byteenable}, 32'hF);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("busy low at done", {31'd0, busy}, 32'd0);
                    check("done expected", exp_done.size(), (exp_done.size() == 0) ? 32'd1 : exp_done.size());
                    if (exp_done.size() != 0) begin
                        ed = exp_done.pop_front();
                        check("error at done", {31'd0, error}, {31'd0, ed.err});
                        check("desc_count at done", {24'd0, desc_count}, {24'd0, ed.cnt});
                    end
                end
                prev_valid = desc_valid; prev_ready = desc_ready;
                prev_buf = desc_buf_addr; prev_len = desc_len; prev_eop = desc_eop;
            end else begin
                prev_valid = 1'b0; prev_ready = 1'b0;
            end
        end
    end

    task automatic start_walk(input logic [6:0] hp);
        @(negedge clk);
        head_ptr = hp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, " completes within budget"}, {31'd0, done_cnt > d0}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " error"}, {31'd0, error}, 32'd0);
        check({tag, " desc_valid"}, {31'd0, desc_valid}, 32'd0);
        check({tag, " mem_chipselect"}, {31'd0, mem_chipselect}, 32'd0);
        check({tag, " mem_write"}, {31'd0, mem_write}, 32'd0);
        check({tag, " desc_count"}, {24'd0, desc_count}, 32'd0);
        check({tag, " mem_address"}, {25'd0, mem_address}, 32'd0);
        check({tag, " mem_writedata"}, mem_writedata, 32'd0);
        check({tag, " desc_buf_addr"}, desc_buf_addr, 32'd0);
        check({tag, " desc_len"}, {16'd0, desc_len}, 32'd0);
        check({tag, " desc_eop"}, {31'd0, desc_eop}, 32'd0);
        check({tag, " mem_clken"}, {31'd0, mem_clken}, 32'd1);
        check({tag, " mem_byteenable"}, {28'd0, mem_byteenable}, 32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0, h0, n;

        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Chain of three owned descriptors, fourth not owned.
        poke_desc(7'h00, 32'h1000_0000, 32'h0000_0004, 32'hABCD_0100, 32'h8000_0000);
        poke_desc(7'h04, 32'h1000_0100, 32'h0000_0008, 32'h0000_0080, 32'h8000_0000);
        poke_desc(7'h08, 32'h1000_0200, 32'h0000_000C, 32'h0000_0044, 32'hC000_0000);
        poke(7'h0F, 32'h0000_0000);
        exp_hs.push_back('{addr: 32'h1000_0000, len: 16'h0100, eop: 1'b0});
        exp_hs.push_back('{addr: 32'h1000_0100, len: 16'h0080, eop: 1'b0});
        exp_hs.push_back('{addr: 32'h1000_0200, len: 16'h0044, eop: 1'b1});
        rsp_q.push_back('{skip: 1'b0, err: 1'b0, len: 16'h0100});
        rsp_q.push_back('{skip: 1'b0, err: 1'b0, len: 16'h0080});
        rsp_q.push_back('{skip: 1'b0, err: 1'b0, len: 16'h0044});
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
        exp_wr.push_back('{addr: 7'h03, data: 32'h0000_0100});
        exp_wr.push_back('{addr: 7'h07, data: 32'h0000_0080});
        exp_wr.push_back('{addr: 7'h0B, data: 32'h4000_0044});
`endif
        exp_done.push_back('{err: 1'b0, cnt: 8'd3});
        d0 = done_cnt; h0 = hs_cnt;
        start_walk(7'h00);
        check("busy after start", {31'd0, busy}, 32'd1);
        n = 0;
        while (!desc_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first desc_valid latency (cycles after cycle 1)", n, 32'd5);
        wait_done(d0, "chain of three");
        check("chain handshake count", hs_cnt - h0, 32'd3);

        // Misaligned head pointer: error and done next cycle, no memory access.
        exp_done.push_back('{err: 1'b1, cnt: 8'd0});
        c0 = cs_cnt; d0 = done_cnt;
        start_walk(7'h02);
        #2 check("misaligned done next cycle", {31'd0, done}, 32'd1);
        check("misaligned error", {31'd0, error}, 32'd1);
        wait_done(d0, "misaligned start");
        check("misaligned no chipselect", cs_cnt - c0, 32'd0);

        // Ready held low for 10 cycles: one stable transfer.
        poke_desc(7'h20, 32'h3000_0000, 32'h0000_0024, 32'h0000_0010, 32'hC000_0000);
        poke(7'h27, 32'h0000_0000);
        exp_hs.push_back('{addr: 32'h3000_0000, len: 16'h0010, eop: 1'b1});
        rsp_q.push_back('{skip: 1'b0, err: 1'b0, len: 16'h0010});
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
        exp_wr.push_back('{addr: 7'h23, data: 32'h4000_0010});
`endif
        exp_done.push_back('{err: 1'b0, cnt: 8'd1});
        stall_cfg = 10; d0 = done_cnt; h0 = hs_cnt;
        start_walk(7'h20);
        wait_done(d0, "stalled ready");
        check("stalled handshake count", hs_cnt - h0, 32'd1);
        stall_cfg = 0;

        // Self-loop descriptor: loop guard trips after MAX_CHAIN completions.
        poke_desc(7'h10, 32'h2000_0000, 32'h0000_0010, 32'h0000_0020, 32'h8000_0000);
        d0 = done_cnt; h0 = hs_cnt;
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
        exp_hs.push_back('{addr: 32'h2000_0000, len: 16'h0020, eop: 1'b0});
        rsp_q.push_back('{skip: 1'b0, err: 1'b0, len: 16'h0020});
        exp_wr.push_back('{addr: 7'h13, data: 32'h0000_0020});
        exp_done.push_back('{err: 1'b0, cnt: 8'd1});
        start_walk(7'h10);
        wait_done(d0, "self-loop");
        check("self-loop handshake count", hs_cnt - h0, 32'd1);
`else
        for (int i = 0; i < MAX_CHAIN; i++) begin
            exp_hs.push_back('{addr: 32'h2000_0000, len: 16'h0020, eop: 1'b0});
            rsp_q.push_back('{skip: 1'b0, err: 1'b0, len: 16'h0020});
        end
        exp_done.push_back('{err: 1'b1, cnt: 8'd4});
        start_walk(7'h10);
        wait_done(d0, "self-loop");
        check("self-loop handshake count", hs_cnt - h0, 32'd4);
`endif

        // Abort while waiting for completion.
        poke_desc(7'h40, 32'h5000_0000, 32'h0000_0044, 32'h0000_0008, 32'h8000_0000);
        exp_hs.push_back('{addr: 32'h5000_0000, len: 16'h0008, eop: 1'b0});
        rsp_q.push_back('{skip: 1'b1, err: 1'b0, len: 16'h0000});
        exp_done.push_back('{err: 1'b0, cnt: 8'd0});
        d0 = done_cnt; h0 = hs_cnt;
        start_walk(7'h40);
        n = 0;
        while (hs_cnt == h0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort test handshake seen", {31'd0, hs_cnt > h0}, 32'd1);
        repeat (3) @(negedge clk);
        check("busy in WAIT_CMP", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2 check("abort done pulse", {31'd0, done}, 32'd1);
        check("abort back to idle", {31'd0, busy}, 32'd0);
        check("abort desc_valid low", {31'd0, desc_valid}, 32'd0);
        wait_done(d0, "abort");

        // DMA error: descriptor written back, walk ends with error.
        poke_desc(7'h30, 32'h4000_0000, 32'h0000_0034, 32'h0000_0040, 32'h8000_0000);
        poke_desc(7'h34, 32'h4000_1000, 32'h0000_0038, 32'h0000_0040, 32'h8000_0000);
        exp_hs.push_back('{addr: 32'h4000_0000, len: 16'h0040, eop: 1'b0});
        rsp_q.push_back('{skip: 1'b0, err: 1'b1, len: 16'h0040});
`ifdef NIOS2OS_DESC_FETCH_WRITEBACK_EN
        exp_wr.push_back('{addr: 7'h33, data: 32'h2000_0040});
`endif
        exp_done.push_back('{err: 1'b1, cnt: 8'd1});
        d0 = done_cnt; h0 = hs_cnt;
        start_walk(7'h30);
        wait_done(d0, "dma error");
        check("dma error handshake count", hs_cnt - h0, 32'd1);

        // Reset asserted mid-FETCH: outputs return to reset values at once.
        start_walk(7'h10);
        @(negedge clk);
        check("busy mid-fetch", {31'd0, busy}, 32'd1);
        check("chipselect mid-fetch", {31'd0, mem_chipselect}, 32'd1);
        #1 reset_n = 1'b0;
        #1 check_reset_values("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        check("handshake queue drained", exp_hs.size(), 32'd0);
        check("write queue drained", exp_wr.size(), 32'd0);
        check("done queue drained", exp_done.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
